// File: rtl/wave_rom_sequencer.sv
// Waveform ROM sequencer: a phase accumulator walks a waveform ROM and streams
// attenuated samples to a DAC, with a shadowed config applied at period boundaries.
module wave_rom_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fword,
  input  logic [15:0]        cfg_cycles,
  input  logic [2:0]         cfg_shift,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_clk_en,
  input  logic [DATA_W-1:0]  rom_rd_data,
  output logic [DATA_W-1:0]  dac_data,
  output logic               dac_valid,
  output logic               busy,
  output logic               period_tick,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LAT);

  // cfg handshake: a word transfers on a rising clk edge where cfg_valid and
  // cfg_ready are both high; cfg_valid may be held until then.
  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               pending_q, pending_d;
  logic [PHASE_W-1:0] sh_fword_q, sh_fword_d;
  logic [15:0]        sh_cycles_q, sh_cycles_d;
  logic [2:0]         sh_shift_q, sh_shift_d;
  logic [PHASE_W-1:0] act_fword_q, act_fword_d;
  logic [15:0]        act_cycles_q, act_cycles_d;
  logic [2:0]         act_shift_q, act_shift_d;
  logic [15:0]        period_cnt_q, period_cnt_d;
  logic               stop_q, stop_d;
  logic [1:0]         drain_cnt_q, drain_cnt_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [2:0]         s1_q, s1_d, s2_q, s2_d;
  logic [DATA_W-1:0]  dac_data_q, dac_data_d;
  logic               dac_valid_q, dac_valid_d;

  logic               cfg_accept;
  logic [PHASE_W:0]   sum;
  logic               wrap;
  logic               stop_seen;
  logic               last_period;
  logic               tap_v;
  logic [2:0]         tap_s;

  assign cfg_ready   = (state_q == ST_IDLE) || !pending_q;
  assign cfg_accept  = cfg_valid && cfg_ready;
  assign sum         = {1'b0, phase_q} + {1'b0, act_fword_q};
  assign wrap        = sum[PHASE_W];
  assign stop_seen   = stop || stop_q;
  assign last_period = (act_cycles_q != 16'd0) && ((period_cnt_q + 16'd1) == act_cycles_q);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rom_addr_d   = rom_addr_q;
    pending_d    = pending_q;
    sh_fword_d   = sh_fword_q;
    sh_cycles_d  = sh_cycles_q;
    sh_shift_d   = sh_shift_q;
    act_fword_d  = act_fword_q;
    act_cycles_d = act_cycles_q;
    act_shift_d  = act_shift_q;
    period_cnt_d = period_cnt_q;
    stop_d       = stop_q;
    drain_cnt_d  = drain_cnt_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start && !stop) begin
          state_d      = ST_RUN;
          phase_d      = '0;
          rom_addr_d   = '0;
          period_cnt_d = '0;
          act_fword_d  = sh_fword_q;
          act_cycles_d = sh_cycles_q;
          act_shift_d  = sh_shift_q;
          pending_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) stop_d = 1'b1;
        // A zero tuning word never wraps, so a stop request cannot wait for one.
        if (stop_seen && (act_fword_q == '0)) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          phase_d = sum[PHASE_W-1:0];
          if (wrap) begin
            tick_d       = 1'b1;
            period_cnt_d = period_cnt_q + 16'd1;
            if (last_period || stop_seen) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end else begin
              rom_addr_d = sum[PHASE_W-1 -: ADDR_W];
              if (pending_q) begin
                act_fword_d  = sh_fword_q;
                act_cycles_d = sh_cycles_q;
                act_shift_d  = sh_shift_q;
                pending_d    = 1'b0;
              end
            end
          end else begin
            rom_addr_d = sum[PHASE_W-1 -: ADDR_W];
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only pending_q gates application at a wrap, so a word accepted on the wrap
    // cycle itself waits for the next boundary.
    if (cfg_accept) begin
      sh_fword_d  = cfg_fword;
      sh_cycles_d = cfg_cycles;
      sh_shift_d  = cfg_shift;
      pending_d   = 1'b1;
    end
  end

  // The shift travels with its address through the ROM latency so a
  // config change never splits a sample.
  always_comb begin
    v1_d        = (state_q == ST_RUN);
    s1_d        = act_shift_q;
    v2_d        = v1_q;
    s2_d        = s1_q;
    tap_v       = (ROM_LAT == 1) ? v1_q : v2_q;
    tap_s       = (ROM_LAT == 1) ? s1_q : s2_q;
    dac_valid_d = tap_v;
    dac_data_d  = dac_data_q;
    if (tap_v) dac_data_d = rom_rd_data >> tap_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      rom_addr_q   <= '0;
      pending_q    <= 1'b0;
      sh_fword_q   <= '0;
      sh_cycles_q  <= '0;
      sh_shift_q   <= '0;
      act_fword_q  <= '0;
      act_cycles_q <= '0;
      act_shift_q  <= '0;
      period_cnt_q <= '0;
      stop_q       <= 1'b0;
      drain_cnt_q  <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      v1_q         <= 1'b0;
      s1_q         <= '0;
      v2_q         <= 1'b0;
      s2_q         <= '0;
      dac_data_q   <= '0;
      dac_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rom_addr_q   <= rom_addr_d;
      pending_q    <= pending_d;
      sh_fword_q   <= sh_fword_d;
      sh_cycles_q  <= sh_cycles_d;
      sh_shift_q   <= sh_shift_d;
      act_fword_q  <= act_fword_d;
      act_cycles_q <= act_cycles_d;
      act_shift_q  <= act_shift_d;
      period_cnt_q <= period_cnt_d;
      stop_q       <= stop_d;
      drain_cnt_q  <= drain_cnt_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      v1_q         <= v1_d;
      s1_q         <= s1_d;
      v2_q         <= v2_d;
      s2_q         <= s2_d;
      dac_data_q   <= dac_data_d;
      dac_valid_q  <= dac_valid_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rom_clk_en  = (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign period_tick = tick_q;
  assign done        = done_q;
  assign dac_data    = dac_data_q;
  assign dac_valid   = dac_valid_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/wave_rom_sequencer.md
WAVE_ROM_SEQUENCER -- requirements
Module: wave_rom_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, waveform ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, ROM/DAC sample width.
REQ-003 SHALL have parameter ROM_LAT, default 1, legal 1..2, ROM read latency in clk cycles.
REQ-004 SHALL have parameter PHASE_W, default 32, phase accumulator width (>ADDR_W).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  single-cycle request to begin playback.
REQ-008 stop  input  1  single-cycle request to end playback.
REQ-009 cfg_valid / cfg_ready  input/output  1 each  configuration handshake.
REQ-010 cfg_fword  input  PHASE_W  frequency tuning word.
REQ-011 cfg_cycles  input  16  periods to play; 0 = continuous.
REQ-012 cfg_shift  input  3  amplitude attenuation, right shift 0..7.
REQ-013 rom_addr  output  ADDR_W  registered ROM address.
REQ-014 rom_clk_en  output  1  ROM clock enable, high in RUN and DRAIN.
REQ-015 rom_rd_data  input  DATA_W  ROM read data.
REQ-016 dac_data / dac_valid  output  DATA_W / 1  sample to DAC, qualifier.
REQ-017 busy, period_tick, done  output  1 each  status; tick and done are one-cycle pulses.

Function
REQ-018 States IDLE, RUN, DRAIN; busy = (state != IDLE).
REQ-019 Config accepted on cfg_valid && cfg_ready into shadow registers; sets pending flag.
REQ-020 cfg_ready = 1 in IDLE; in RUN/DRAIN cfg_ready = !pending.
REQ-021 IDLE + start (stop low) -> RUN next cycle; active regs loaded from shadow, pending cleared, phase = 0, period counter = 0.
REQ-022 start and stop together in IDLE: stop wins, stay IDLE; stop alone in IDLE ignored.
REQ-023 RUN: each cycle phase <= phase + fword modulo 2^PHASE_W; rom_addr <= phase[PHASE_W-1 -: ADDR_W] of the updated phase.
REQ-024 Wrap = carry out of accumulator add; period_tick pulses the cycle after a wrap.
REQ-025 At a wrap, if pending, active regs <= shadow and pending cleared; phase continues (no reset to 0).
REQ-026 cfg accepted in the same cycle as a wrap SHALL apply at the following wrap, not the current one.
REQ-027 At a wrap, period counter increments; if cycles != 0 and counter+1 == cycles -> DRAIN.
REQ-028 stop in RUN is latched and takes effect at the next wrap (-> DRAIN); if active fword == 0, stop -> DRAIN next cycle.
REQ-029 Latency: address issued cycle t; rom_rd_data valid t+ROM_LAT; dac_data/dac_valid registered at t+ROM_LAT+1.
REQ-030 dac_data = rom_rd_data >> shift, shift value aligned with the sample's address (shift change SHALL not split a sample).
REQ-031 DRAIN: no new addresses (rom_addr held); stays ROM_LAT+1 cycles until last issued sample leaves; then IDLE with done pulse in the first IDLE cycle.
REQ-032 dac_valid high only for samples whose address was issued in RUN; dac_data holds last value when dac_valid low.
REQ-033 Counter of 16 bits SHALL not overflow in continuous mode (wraps 65535->0 harmlessly).

Reset
REQ-034 On rst_n low at a clk edge: state IDLE, phase 0, rom_addr 0, rom_clk_en 0, dac_data 0, dac_valid 0, busy 0, period_tick 0, done 0, cfg_ready 1, pending 0, shadow/active regs 0.
REQ-035 Reset mid-RUN or mid-DRAIN SHALL abort immediately; no done pulse; in-flight samples discarded.

Verification
REQ-036 cfg fword=2^22, cycles=2, shift=0, start -> rom_addr 0,1,2..1023,0..1023; exactly 2048 dac_valid cycles, 2 period_ticks, done once, first dac_valid ROM_LAT+1 cycles after first address.
REQ-037 cycles=0, fword=2^23, stop mid-period at addr 500 -> playback continues to wrap, DRAIN, done; last address 1022.
REQ-038 During RUN change fword 2^22->2^23 and shift 0->1 -> old values until next wrap, then step 2 and halved samples; cfg_ready low while pending.
REQ-039 cfg_valid asserted on exact wrap cycle -> new cfg applied one period later.
REQ-040 start+stop same cycle in IDLE -> remains IDLE; fword=0 then stop -> DRAIN next cycle, done.
REQ-041 rst_n low during RUN at addr 300 -> all outputs reset values next edge, no done; run for ROM_LAT=1 and 2.
